// File: rtl/line_window_buffer.sv
// line_window_buffer
//   Multi-row line buffer for the convolution datapath. Accepts one raster
//   pixel per beat and presents K vertically aligned taps per beat: the
//   newest pixel plus the same column from the previous K-1 lines.
//
// Ports
//   clk          clock
//   rst          asynchronous, active-high reset
//   clear        synchronous flush; also latches cfg_line_len
//   cfg_line_len active line length, sampled only on clear (0 or >MAX_LINE
//                selects MAX_LINE)
//   in_valid     input beat valid
//   in_ready     buffer can accept a beat
//   in_data      input pixel
//   out_valid    tap vector valid
//   out_ready    downstream accepts the tap vector
//   out_taps     tap k in bits [k*DATA_WIDTH +: DATA_WIDTH]; tap 0 newest,
//                tap k is k lines earlier in the same column
//   out_col      column index of the tap vector
//   fill_lines   completed lines stored, saturating at K-1
module line_window_buffer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned K          = 3,
  parameter int unsigned MAX_LINE   = 64,
  parameter int unsigned LW         = $clog2(MAX_LINE + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic [LW-1:0]           cfg_line_len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [K*DATA_WIDTH-1:0] out_taps,
  output logic [LW-1:0]           out_col,
  output logic [$clog2(K):0]      fill_lines
);

  localparam int unsigned NROW = K - 1;
  localparam int unsigned TAPW = K * DATA_WIDTH;
  localparam int unsigned FW   = $clog2(K) + 1;
  localparam int unsigned AW   = (MAX_LINE > 1) ? $clog2(MAX_LINE) : 1;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_row [NROW][MAX_LINE];
  logic [LW-1:0]         r_col;
  logic [FW-1:0]         r_fill;
  logic [LW-1:0]         r_line_len;
  logic                  r_out_valid;
  logic [TAPW-1:0]       r_out_taps;
  logic [LW-1:0]         r_out_col;

  // ---------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------
  logic                  w_accept;
  logic                  w_xfer;
  logic                  w_last_col;
  logic                  w_fill_full;
  logic [AW-1:0]         w_addr;
  logic [LW-1:0]         w_len_clamped;
  logic [DATA_WIDTH-1:0] w_rd [NROW];
  logic [TAPW-1:0]       w_taps_next;

  // Single output register: a beat can enter whenever the register is
  // empty or is being drained this cycle. clear does not gate readiness.
  assign in_ready    = !r_out_valid || out_ready;
  assign w_accept    = in_valid && in_ready;
  assign w_xfer      = r_out_valid && out_ready;

  // Column pointer never exceeds MAX_LINE-1, so the low bits address a row.
  assign w_addr      = r_col[AW-1:0];
  assign w_last_col  = (r_col == (r_line_len - LW'(1)));
  assign w_fill_full = (r_fill == FW'(NROW));

  // Out-of-range line lengths fall back to the full storage depth.
  assign w_len_clamped = ((cfg_line_len == LW'(0)) || (cfg_line_len > LW'(MAX_LINE)))
                         ? LW'(MAX_LINE) : cfg_line_len;

  // Pre-write read of every row at the current column.
  always_comb begin
    for (int k = 0; k < NROW; k++) begin
      w_rd[k] = r_row[k][w_addr];
    end
  end

  // Tap vector for the accepted beat: newest pixel, then older rows.
  always_comb begin
    w_taps_next = '0;
    w_taps_next[0 +: DATA_WIDTH] = in_data;
    for (int k = 1; k < K; k++) begin
      w_taps_next[k*DATA_WIDTH +: DATA_WIDTH] = w_rd[k-1];
    end
  end

  // ---------------------------------------------------------------------
  // Row storage: each row is a circular memory indexed by column; an
  // accepted beat pushes the column one row deeper (row k <- row k-1).
  // clear leaves contents alone; stale data is masked by r_fill.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NROW; k++) begin
        for (int a = 0; a < MAX_LINE; a++) begin
          r_row[k][a] <= '0;
        end
      end
    end else if (!clear && w_accept) begin
      r_row[0][w_addr] <= in_data;
      for (int k = 1; k < NROW; k++) begin
        r_row[k][w_addr] <= w_rd[k-1];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Column pointer, fill tracker and latched line length.
  // Wrap and fill increment happen on the same accepted beat.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col      <= '0;
      r_fill     <= '0;
      r_line_len <= LW'(MAX_LINE);
    end else if (clear) begin
      r_col      <= '0;
      r_fill     <= '0;
      r_line_len <= w_len_clamped;
    end else if (w_accept) begin
      if (w_last_col) begin
        r_col <= '0;
        if (!w_fill_full) begin
          r_fill <= r_fill + FW'(1);
        end
      end else begin
        r_col <= r_col + LW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output register. Valid only once every tap holds a real line; taps
  // and column hold while stalled because no beat is accepted then.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_taps  <= '0;
      r_out_col   <= '0;
    end else if (clear) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= w_fill_full;
      r_out_taps  <= w_taps_next;
      r_out_col   <= r_col;
    end else if (w_xfer) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_taps   = r_out_taps;
  assign out_col    = r_out_col;
  assign fill_lines = r_fill;

endmodule

// File: doc/line_window_buffer.md
Name: line_window_buffer

Overview:
- Multi-row, runtime-configurable line buffer for the convolution datapath; successor to the single-tap delay shifter.
- Accepts one pixel per beat from a raster stream and presents K vertically aligned taps per beat: current pixel plus the same column from the previous K-1 lines.
- Adds valid/ready flow control, a runtime line length, a fill tracker, a synchronous flush, and a registered output stage.
- Sits between the input feature-map reader and the KxK window/MAC array.

Parameters:
- DATA_WIDTH, 8, bits per pixel.
- K, 3, number of row taps (kernel height), >=2.
- MAX_LINE, 64, maximum line length in pixels (storage depth per row).
- LW, $clog2(MAX_LINE+1), width of line-length and column fields.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush; also latches cfg_line_len.
- cfg_line_len  in  LW  active line length; sampled only on clear.
- in_valid  in  1  input beat valid.
- in_ready  out  1  buffer can accept a beat.
- in_data  in  DATA_WIDTH  input pixel.
- out_valid  out  1  tap vector valid.
- out_ready  in  1  downstream accepts the tap vector.
- out_taps  out  K*DATA_WIDTH  tap k in bits [k*DATA_WIDTH +: DATA_WIDTH].
  - tap 0 is the newest pixel.
  - tap k is the pixel k lines earlier, same column.
- out_col  out  LW  column index of the tap vector.
- fill_lines  out  $clog2(K)+1  completed lines stored, saturating at K-1.

Behaviour:
Reset (rst high, async):
- All row memories 0, column pointer 0, fill_lines 0.
- out_valid 0, out_taps 0, out_col 0, line_len_q = MAX_LINE.
- in_ready is 1 after reset.

Handshake:
- Accept = in_valid && in_ready.
- in_ready = !out_valid || out_ready (single output register; no bubble under continuous flow).
- Output transfer = out_valid && out_ready.
- out_taps and out_col hold stable while out_valid && !out_ready.

On accept, with col being the current column pointer:
- Next registered taps:
  - tap0 = in_data.
  - tapk = row[k-1][col] read value, for k = 1..K-1 (pre-write value).
- row[0][col] <= in_data.
- row[k][col] <= row[k-1][col] (pre-write value), for k = 1..K-2.
- out_col <= col.
- Column pointer: if col == line_len_q-1, wrap to 0 and increment fill_lines, saturating at K-1; else col+1.

Output register:
- out_valid <= 1 on accept only when fill_lines == K-1 (all taps hold real lines); else cleared.
- Beats accepted during priming update storage but produce no output.
- When there is no accept: out_valid <= 0 on transfer, else held.
- Latency: 1 cycle from accepted input to out_valid.

Clear (synchronous):
- Zeroes the column pointer, fill_lines, and out_valid.
- Latches line_len_q from cfg_line_len, clamped: 0 or >MAX_LINE -> MAX_LINE.
- Row memory contents are not required to be zeroed; they are masked by fill_lines.
- clear with a simultaneous accept: clear wins; the beat is dropped and in_ready is not qualified by clear.

Boundaries:
- line_len_q = 1: every beat wraps; fill_lines saturates after K-1 beats.
- Column wrap and the fill_lines increment occur on the same accept.
- The first out_valid occurs on the first beat of line K-1, counting lines from 0.
- Stall (in_valid low): no state change.
- Backpressure with in_valid high: no accept, no storage change.
- rst mid-stream: immediate return to reset state; stream restarts priming.
- Storage is implemented as K-1 circular row memories of MAX_LINE entries (regs or inferred RAM with registered read-through semantics as above). No shift-by-MAX_LINE chains.

Test Plan:
- Reset, K=3, clear with cfg_line_len=4, stream 0..15 continuously with out_ready=1:
  - no out_valid for beats 0..7.
  - beat 8 -> out_valid next cycle, taps {0,4,8} (tap2,tap1,tap0), out_col 0.
  - beat 15 -> taps {7,11,15}, out_col 3.
- Same stream with out_ready toggling 1,0: out_taps stable while stalled, no tap vector lost or duplicated, 8 transfers total, in_ready low exactly on stall cycles with out_valid high.
- cfg_line_len=0 and cfg_line_len=MAX_LINE+1 on clear: line_len_q = MAX_LINE, so the first out_valid follows beat 2*MAX_LINE.
- Mid-line clear at beat 6, with cfg_line_len=2 and in_valid high: that beat is dropped, fill_lines=0, and the first output follows the 5th post-clear beat with taps {p0,p2,p4}.
- Async rst asserted while out_valid=1 and out_ready=0: out_valid, fill_lines, and out_col drop to 0 immediately; in_ready=1 after release.
- line_len=1, K=3, stream 10,11,12,13: outputs {10,11,12} then {11,12,13}.
